mc_ctrl_hs: RTL and testbench

Next-generation multicycle RV32 control FSM with handshaked, variable-latency memory (req/ready), an optional RV32M multiply/divide sequencing state, and a trap state for illegal instructions and memory timeouts. It drives the existing multicycle datapath muxes and emits `alu_op` to the existing ALU decoder. It also produces byte/half/word access sizing for loads and stores.

---
 rtl/mc_ctrl_hs.sv | 296 +++++++++++++++++++++++++++++
 tb/tb_mc_ctrl_hs.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl_hs.sv
// mc_ctrl_hs: multicycle RV32 control FSM with handshaked memory, optional
// RV32M sequencing and a trap state for illegal instructions / memory timeouts.
// Ports:
//   clk, reset (async, active-high)
//   op/funct3/funct7      instruction fields from the IR
//   zero, alu_lsb         ALU flags for branch decisions
//   mem_ready, md_done    handshake completions from memory and mul/div unit
//   mem_req/mem_we/mem_size, adr_src, ir_write, pc_write, pc_src,
//   alu_src_a/b, alu_op, imm_src, result_src, reg_write   datapath control
//   md_start, md_sel      mul/div launch and writeback select
//   trap, trap_cause      halt indication and reason
//   state_dbg             current state encoding
// Control outputs are decoded combinationally from the state and the current
// handshake inputs, because strobes such as ir_write must fire in the same
// cycle the memory reports ready.
module mc_ctrl_hs #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned ENABLE_MEXT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       zero,
  input  logic       alu_lsb,
  input  logic       mem_ready,
  input  logic       md_done,
  output logic       mem_req,
  output logic       mem_we,
  output logic [1:0] mem_size,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [2:0] imm_src,
  output logic [1:0] result_src,
  output logic       reg_write,
  output logic       md_start,
  output logic       md_sel,
  output logic       trap,
  output logic [1:0] trap_cause,
  output logic [3:0] state_dbg
);

  localparam int unsigned CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MEM_TIMEOUT - 1);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_BR    = 7'b1100011;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_EXECU    = 4'd8,
    S_EXECMD   = 4'd9,
    S_JAL      = 4'd10,
    S_BRANCH   = 4'd11,
    S_ALUWB    = 4'd12,
    S_TRAP     = 4'd13
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          md_q, md_d;
  logic [1:0]    cause_q, cause_d;
  logic          tmo_hit;
  logic          is_md;
  logic          taken;

  assign is_md     = (ENABLE_MEXT != 0) && (op == OP_R) && (funct7 == 7'b0000001);
  // funct3[2] selects signed/unsigned compare vs equality; funct3[0] inverts.
  assign taken     = (funct3[2] ? alu_lsb : zero) ^ funct3[0];
  // The final allowed not-ready cycle in a memory wait; ready in it still wins.
  assign tmo_hit   = (MEM_TIMEOUT != 0) && !mem_ready && (cnt_q == CNT_LAST);
  assign trap_cause = cause_q;
  assign state_dbg  = state_q;

  // State, wait counter, mul/div launch flag and trap cause registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
      md_q    <= 1'b0;
      cause_q <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      md_q    <= md_d;
      cause_q <= cause_d;
    end
  end

  // Next-state and control decode.
  always_comb begin
    state_d    = state_q;
    cnt_d      = '0;
    md_d       = 1'b0;
    cause_d    = cause_q;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_size   = 2'b00;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    imm_src    = 3'b000;
    result_src = 2'b00;
    reg_write  = 1'b0;
    md_start   = 1'b0;
    md_sel     = 1'b0;
    trap       = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_req    = 1'b1;
        mem_size   = 2'b10;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end else if (tmo_hit) begin
          state_d = S_TRAP;
          cause_d = 2'b10;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_DECODE: begin
        alu_src_a = ((op == OP_JAL) || (op == OP_BR)) ? 2'b01 : 2'b10;
        alu_src_b = 2'b01;
        state_d   = S_TRAP;
        case (op)
          OP_LOAD: begin
            if (!((funct3 == 3'b011) || (funct3[2:1] == 2'b11))) state_d = S_MEMADR;
          end
          OP_STORE: begin
            imm_src = 3'b001;
            if (funct3 < 3'b011) state_d = S_MEMADR;
          end
          OP_R: begin
            if ((funct7 == 7'b0000000) || (funct7 == 7'b0100000)) state_d = S_EXECR;
            else if (is_md) state_d = S_EXECMD;
          end
          OP_IMM, OP_JALR: state_d = S_EXECI;
          OP_LUI, OP_AUIPC: begin
            imm_src = 3'b011;
            state_d = S_EXECU;
          end
          OP_JAL: begin
            imm_src = 3'b100;
            state_d = S_JAL;
          end
          OP_BR: begin
            imm_src = 3'b010;
            if (funct3[2:1] != 2'b01) state_d = S_BRANCH;
          end
          default: state_d = S_TRAP;
        endcase
        if (state_d == S_TRAP) cause_d = 2'b01;
      end

      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        imm_src   = (op == OP_STORE) ? 3'b001 : 3'b000;
        state_d   = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      end

      S_MEMREAD, S_MEMWRITE: begin
        mem_req  = 1'b1;
        adr_src  = 1'b1;
        mem_size = funct3[1:0];
        mem_we   = (state_q == S_MEMWRITE);
        if (mem_ready) begin
          state_d = (state_q == S_MEMREAD) ? S_MEMWB : S_FETCH;
        end else if (tmo_hit) begin
          state_d = S_TRAP;
          cause_d = 2'b10;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      S_MEMWB: begin
        reg_write  = 1'b1;
        result_src = 2'b01;
        state_d    = S_FETCH;
      end

      S_EXECR: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end

      S_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
        imm_src   = (funct3[1:0] == 2'b01) ? 3'b101 : 3'b000;
        if (op == OP_JALR) begin
          pc_write = 1'b1;
          pc_src   = 1'b1;
        end
        state_d = S_ALUWB;
      end

      S_EXECU: begin
        alu_src_a = (op == OP_LUI) ? 2'b11 : 2'b01;
        alu_src_b = 2'b01;
        imm_src   = 3'b011;
        state_d   = S_ALUWB;
      end

      // Launch once, then wait; md_done in the launch cycle is accepted.
      S_EXECMD: begin
        md_start = !md_q;
        if (md_done) state_d = S_ALUWB;
        else         md_d    = 1'b1;
      end

      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        imm_src   = 3'b100;
        pc_write  = 1'b1;
        pc_src    = 1'b1;
        state_d   = S_ALUWB;
      end

      S_BRANCH: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b11;
        imm_src   = 3'b010;
        pc_write  = taken;
        pc_src    = taken;
        state_d   = S_FETCH;
      end

      S_ALUWB: begin
        reg_write  = 1'b1;
        result_src = ((op == OP_JAL) || (op == OP_JALR)) ? 2'b11 : 2'b00;
        md_sel     = is_md;
        state_d    = S_FETCH;
      end

      S_TRAP: trap = 1'b1;

      default: state_d = S_FETCH;
    endcase

    // Nothing is strobed while reset is held, including the FETCH request.
    if (reset) begin
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      mem_size   = 2'b00;
      adr_src    = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_src     = 1'b0;
      alu_src_a  = 2'b00;
      alu_src_b  = 2'b00;
      alu_op     = 2'b00;
      imm_src    = 3'b000;
      result_src = 2'b00;
      reg_write  = 1'b0;
      md_start   = 1'b0;
      md_sel     = 1'b0;
      trap       = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_ctrl_hs.sv
// Testbench for mc_ctrl_hs. Two instances run side by side with independent
// stimulus: instance 0 uses MEM_TIMEOUT=16 / ENABLE_MEXT=1, instance 1 uses
// MEM_TIMEOUT=4 / ENABLE_MEXT=0. Each instruction is scripted as a list of
// expected per-cycle output vectors; a negedge monitor pops and compares.
module tb_mc_ctrl_hs;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_BR    = 7'b1100011;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic [1:0] mem_size;
    logic       adr_src;
    logic       ir_write;
    logic       pc_write;
    logic       pc_src;
    logic [1:0] a;
    logic [1:0] b;
    logic [1:0] alu_op;
    logic [2:0] imm;
    logic [1:0] res;
    logic       reg_write;
    logic       md_start;
    logic       md_sel;
    logic       trap;
    logic [1:0] cause;
    logic [3:0] st;
  } outv_t;

  typedef enum int {C_LOAD, C_STORE, C_R, C_MD, C_I, C_U, C_JAL, C_BR, C_ILL} cls_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_s [2];
  logic [6:0] op_s  [2];
  logic [2:0] f3_s  [2];
  logic [6:0] f7_s  [2];
  logic       z_s   [2];
  logic       lsb_s [2];
  logic       rdy_s [2];
  logic       done_s[2];

  logic       req_o [2];
  logic       we_o  [2];
  logic [1:0] size_o[2];
  logic       adr_o [2];
  logic       irw_o [2];
  logic       pcw_o [2];
  logic       pcs_o [2];
  logic [1:0] a_o   [2];
  logic [1:0] b_o   [2];
  logic [1:0] aop_o [2];
  logic [2:0] imm_o [2];
  logic [1:0] res_o [2];
  logic       rw_o  [2];
  logic       mds_o [2];
  logic       mdl_o [2];
  logic       trap_o[2];
  logic [1:0] cause_o[2];
  logic [3:0] st_o  [2];
  outv_t      act   [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mc_ctrl_hs #(
      .MEM_TIMEOUT((g == 0) ? 16 : 4),
      .ENABLE_MEXT((g == 0) ? 1 : 0)
    ) u_dut (
      .clk(clk), .reset(rst_s[g]), .op(op_s[g]), .funct3(f3_s[g]), .funct7(f7_s[g]),
      .zero(z_s[g]), .alu_lsb(lsb_s[g]), .mem_ready(rdy_s[g]), .md_done(done_s[g]),
      .mem_req(req_o[g]), .mem_we(we_o[g]), .mem_size(size_o[g]), .adr_src(adr_o[g]),
      .ir_write(irw_o[g]), .pc_write(pcw_o[g]), .pc_src(pcs_o[g]),
      .alu_src_a(a_o[g]), .alu_src_b(b_o[g]), .alu_op(aop_o[g]), .imm_src(imm_o[g]),
      .result_src(res_o[g]), .reg_write(rw_o[g]), .md_start(mds_o[g]), .md_sel(mdl_o[g]),
      .trap(trap_o[g]), .trap_cause(cause_o[g]), .state_dbg(st_o[g])
    );
    assign act[g] = {req_o[g], we_o[g], size_o[g], adr_o[g], irw_o[g], pcw_o[g], pcs_o[g],
                     a_o[g], b_o[g], aop_o[g], imm_o[g], res_o[g], rw_o[g], mds_o[g],
                     mdl_o[g], trap_o[g], cause_o[g], st_o[g]};
  end

  int    checks   = 0;
  int    failures = 0;
  int    ncyc[2];
  outv_t q0[$];
  outv_t q1[$];
  outv_t mon_e;
  bit    mon_have;

  function automatic int unsigned tmo_of(input int k);
    return (k == 0) ? 16 : 4;
  endfunction

  function automatic bit mext_of(input int k);
    return (k == 0);
  endfunction

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic outv_t ev(input logic [3:0] st);
    outv_t e;
    e    = '0;
    e.st = st;
    return e;
  endfunction

  function automatic cls_t classify(input int k, input logic [6:0] op,
                                    input logic [2:0] f3, input logic [6:0] f7);
    case (op)
      OP_LOAD:  return (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) ? C_LOAD : C_ILL;
      OP_STORE: return (f3 <= 3'd2) ? C_STORE : C_ILL;
      OP_R: begin
        if (f7 == 7'h00 || f7 == 7'h20) return C_R;
        if (f7 == 7'h01 && mext_of(k)) return C_MD;
        return C_ILL;
      end
      OP_IMM, OP_JALR:  return C_I;
      OP_LUI, OP_AUIPC: return C_U;
      OP_JAL:           return C_JAL;
      OP_BR:            return (f3 == 3'd2 || f3 == 3'd3) ? C_ILL : C_BR;
      default:          return C_ILL;
    endcase
  endfunction

  // One clock of stimulus with its expected output vector.
  task automatic cyc(input int k, input logic rst, input logic rdy, input logic done,
                     input outv_t e);
    rst_s[k]  = rst;
    rdy_s[k]  = rdy;
    done_s[k] = done;
    if (k == 0) q0.push_back(e);
    else        q1.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int k, input int n);
    repeat (n) cyc(k, 1'b1, rnd(), rnd(), '0);
  endtask

  task automatic do_trap(input int k, input logic [1:0] cause);
    outv_t e;
    e       = ev(4'd13);
    e.trap  = 1'b1;
    e.cause = cause;
    repeat (3) cyc(k, 1'b0, rnd(), rnd(), e);
    do_reset(k, 1);
  endtask

  // Memory wait: nrdy not-ready cycles then a ready cycle, unless the
  // instance's timeout budget runs out first.
  task automatic mem_phase(input int k, input outv_t ew, input outv_t ed, input int nrdy,
                           output bit timed_out);
    int unsigned t;
    t = tmo_of(k);
    if (t != 0 && nrdy >= int'(t)) begin
      repeat (t) cyc(k, 1'b0, 1'b0, rnd(), ew);
      timed_out = 1'b1;
    end else begin
      repeat (nrdy) cyc(k, 1'b0, 1'b0, rnd(), ew);
      cyc(k, 1'b0, 1'b1, rnd(), ed);
      timed_out = 1'b0;
    end
  endtask

  function automatic outv_t fetch_e();
    outv_t e;
    e          = ev(4'd0);
    e.mem_req  = 1'b1;
    e.mem_size = 2'b10;
    e.b        = 2'b10;
    e.res      = 2'b10;
    return e;
  endfunction

  task automatic run_instr(input int k, input logic [6:0] op, input logic [2:0] f3,
                           input logic [6:0] f7, input logic z, input logic lsb,
                           input int fw, input int mw, input int dw);
    outv_t e, ew, ed;
    bit    to, wb;
    cls_t  c;
    op_s[k] = op; f3_s[k] = f3; f7_s[k] = f7; z_s[k] = z; lsb_s[k] = lsb;
    ew = fetch_e();
    ed = ew; ed.ir_write = 1'b1; ed.pc_write = 1'b1;
    mem_phase(k, ew, ed, fw, to);
    if (to) begin
      do_trap(k, 2'b10);
      return;
    end
    c   = classify(k, op, f3, f7);
    e   = ev(4'd1);
    e.a = (op == OP_JAL || op == OP_BR) ? 2'b01 : 2'b10;
    e.b = 2'b01;
    case (op)
      OP_STORE:         e.imm = 3'b001;
      OP_BR:            e.imm = 3'b010;
      OP_LUI, OP_AUIPC: e.imm = 3'b011;
      OP_JAL:           e.imm = 3'b100;
      default:          e.imm = 3'b000;
    endcase
    cyc(k, 1'b0, rnd(), rnd(), e);
    wb = 1'b1;
    case (c)
      C_ILL: begin
        do_trap(k, 2'b01);
        return;
      end
      C_LOAD, C_STORE: begin
        wb = 1'b0;
        e = ev(4'd2); e.a = 2'b10; e.b = 2'b01;
        e.imm = (c == C_STORE) ? 3'b001 : 3'b000;
        cyc(k, 1'b0, rnd(), rnd(), e);
        ew = ev((c == C_STORE) ? 4'd5 : 4'd3);
        ew.mem_req = 1'b1; ew.adr_src = 1'b1; ew.mem_size = f3[1:0];
        ew.mem_we = (c == C_STORE);
        mem_phase(k, ew, ew, mw, to);
        if (to) begin
          do_trap(k, 2'b10);
          return;
        end
        if (c == C_LOAD) begin
          e = ev(4'd4); e.reg_write = 1'b1; e.res = 2'b01;
          cyc(k, 1'b0, rnd(), rnd(), e);
        end
      end
      C_R: begin
        e = ev(4'd6); e.a = 2'b10; e.alu_op = 2'b10;
        cyc(k, 1'b0, rnd(), rnd(), e);
      end
      C_I: begin
        e = ev(4'd7); e.a = 2'b10; e.b = 2'b01; e.alu_op = 2'b10;
        e.imm = (f3 == 3'd1 || f3 == 3'd5) ? 3'b101 : 3'b000;
        e.pc_write = (op == OP_JALR); e.pc_src = (op == OP_JALR);
        cyc(k, 1'b0, rnd(), rnd(), e);
      end
      C_U: begin
        e = ev(4'd8); e.a = (op == OP_LUI) ? 2'b11 : 2'b01; e.b = 2'b01; e.imm = 3'b011;
        cyc(k, 1'b0, rnd(), rnd(), e);
      end
      C_MD: begin
        for (int i = 0; i <= dw; i++) begin
          e = ev(4'd9); e.md_start = (i == 0);
          cyc(k, 1'b0, rnd(), (i == dw), e);
        end
      end
      C_JAL: begin
        e = ev(4'd10); e.a = 2'b01; e.b = 2'b01; e.imm = 3'b100;
        e.pc_write = 1'b1; e.pc_src = 1'b1;
        cyc(k, 1'b0, rnd(), rnd(), e);
      end
      default: begin
        logic tk;
        wb = 1'b0;
        case (f3)
          3'd0:       tk = z;
          3'd1:       tk = !z;
          3'd4, 3'd6: tk = lsb;
          default:    tk = !lsb;
        endcase
        e = ev(4'd11); e.a = 2'b10; e.alu_op = 2'b11; e.imm = 3'b010;
        e.pc_write = tk; e.pc_src = tk;
        cyc(k, 1'b0, rnd(), rnd(), e);
      end
    endcase
    if (wb) begin
      e = ev(4'd12); e.reg_write = 1'b1;
      e.res = (op == OP_JAL || op == OP_JALR) ? 2'b11 : 2'b00;
      e.md_sel = (c == C_MD);
      cyc(k, 1'b0, rnd(), rnd(), e);
    end
  endtask

  // Reset lands while a fetch is still waiting for memory.
  task automatic reset_mid(input int k);
    repeat (2) cyc(k, 1'b0, 1'b0, rnd(), fetch_e());
    do_reset(k, 2);
  endtask

  task automatic run(input int k);
    logic [6:0] op, f7;
    logic [2:0] f3;
    int r, fw, mw;
    do_reset(k, 2);
    run_instr(k, OP_LOAD,  3'd2, 7'h00, 1'b0, 1'b0, 2, 3, 0);
    run_instr(k, OP_LOAD,  3'd0, 7'h00, 1'b0, 1'b0, 0, 1, 0);
    run_instr(k, OP_STORE, 3'd2, 7'h00, 1'b0, 1'b0, 0, 3, 0);
    run_instr(k, OP_STORE, 3'd1, 7'h00, 1'b0, 1'b0, 1, 4, 0);
    run_instr(k, 7'h00,    3'd0, 7'h00, 1'b0, 1'b0, 0, 0, 0);
    run_instr(k, OP_BR,    3'd2, 7'h00, 1'b0, 1'b0, 0, 0, 0);
    run_instr(k, OP_R,     3'd0, 7'h01, 1'b0, 1'b0, 1, 0, 5);
    run_instr(k, OP_R,     3'd4, 7'h01, 1'b0, 1'b0, 0, 0, 0);
    run_instr(k, OP_BR,    3'd1, 7'h00, 1'b0, 1'b0, 0, 0, 0);
    run_instr(k, OP_BR,    3'd0, 7'h00, 1'b0, 1'b0, 0, 0, 0);
    run_instr(k, OP_BR,    3'd5, 7'h00, 1'b0, 1'b1, 0, 0, 0);
    run_instr(k, OP_BR,    3'd6, 7'h00, 1'b1, 1'b1, 0, 0, 0);
    run_instr(k, OP_JAL,   3'd0, 7'h00, 1'b0, 1'b0, 0, 0, 0);
    run_instr(k, OP_JALR,  3'd0, 7'h00, 1'b0, 1'b0, 0, 0, 0);
    run_instr(k, OP_LUI,   3'd0, 7'h00, 1'b0, 1'b0, 0, 0, 0);
    run_instr(k, OP_AUIPC, 3'd0, 7'h00, 1'b0, 1'b0, 0, 0, 0);
    run_instr(k, OP_R,     3'd0, 7'h20, 1'b0, 1'b0, 0, 0, 0);
    run_instr(k, OP_IMM,   3'd1, 7'h00, 1'b0, 1'b0, 0, 0, 0);
    run_instr(k, OP_R,     3'd0, 7'h10, 1'b0, 1'b0, 0, 0, 0);
    reset_mid(k);
    run_instr(k, OP_IMM,   3'd0, 7'h00, 1'b0, 1'b0, 15, 0, 0);
    run_instr(k, OP_IMM,   3'd0, 7'h00, 1'b0, 1'b0, 16, 0, 0);
    for (int n = 0; n < 150; n++) begin
      r  = int'($urandom_range(0, 10));
      f3 = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0:       f7 = 7'h00;
        1:       f7 = 7'h20;
        2:       f7 = 7'h01;
        default: f7 = 7'($urandom_range(0, 127));
      endcase
      case (r)
        0: op = OP_LOAD;  1: op = OP_STORE; 2: op = OP_R;   3: op = OP_IMM;
        4: op = OP_JALR;  5: op = OP_LUI;   6: op = OP_AUIPC; 7: op = OP_JAL;
        8: op = OP_BR;    9: op = ($urandom_range(0, 1) != 0) ? 7'h00 : 7'h73;
        default: op = OP_R;
      endcase
      if (op == OP_JALR) f3 = 3'd0;
      fw = ($urandom_range(0, 15) == 0) ? 20 : int'($urandom_range(0, 3));
      mw = ($urandom_range(0, 15) == 0) ? 20 : int'($urandom_range(0, 5));
      if (r == 10) reset_mid(k);
      else run_instr(k, op, f3, f7, rnd(), rnd(), fw, mw, int'($urandom_range(0, 6)));
    end
  endtask

  // Monitor: compare every presented cycle against the scripted expectation.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      mon_have = 1'b0;
      if (k == 0 && q0.size() != 0) begin
        mon_e = q0.pop_front(); mon_have = 1'b1;
      end else if (k == 1 && q1.size() != 0) begin
        mon_e = q1.pop_front(); mon_have = 1'b1;
      end
      if (mon_have) begin
        checks++;
        if (act[k] !== mon_e) begin
          failures++;
          $display("FAIL inst%0d_cycle%0d: got %h (state %0d) expected %h (state %0d)",
                   k, ncyc[k], act[k], act[k].st, mon_e, mon_e.st);
        end
        ncyc[k]++;
      end
    end
  end

  initial begin
    ncyc[0] = 0;
    ncyc[1] = 0;
    for (int k = 0; k < 2; k++) begin
      rst_s[k] = 1'b1; op_s[k] = '0; f3_s[k] = '0; f7_s[k] = '0;
      z_s[k] = 1'b0; lsb_s[k] = 1'b0; rdy_s[k] = 1'b0; done_s[k] = 1'b0;
    end
    @(posedge clk);
    #1;
    fork
      run(0);
      run(1);
    join
    repeat (2) @(posedge clk);
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      failures++;
      $display("FAIL queue_drain: left %0d/%0d entries, required 0/0", q0.size(), q1.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
